// File: rtl/gen_cmd_parser.sv
// gen_cmd_parser: turns the serial command byte stream into the function
// generator's mode/freq controls and answers every command with a one-byte
// status ('K' accepted, 'E' rejected, aborted or unknown opcode).
// mode, freq and update are registered. They change only on the edge that
// enters APPLY, so update is high in the same cycle the new value shows up.
// An acknowledge is held as a pending byte. new_tx_data is that pending flag
// gated by tx_busy, so the strobe comes out in the first cycle the
// transmitter is free.
module gen_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd5000000,
    parameter int unsigned MAX_FREQ       = 32'd25000000,
    parameter int unsigned DEFAULT_FREQ   = 32'd1000,
    parameter logic [1:0]  DEFAULT_MODE   = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    output logic [1:0]  mode,
    output logic [31:0] freq,
    output logic        update
);

    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [31:0] MAX_FREQ_W = 32'(MAX_FREQ);
    localparam logic [31:0] DEF_FREQ_W = 32'(DEFAULT_FREQ);

    localparam logic [7:0] OP_MODE  = 8'h4D;
    localparam logic [7:0] OP_FREQ  = 8'h46;
    localparam logic [7:0] OP_RST   = 8'h52;
    localparam logic [7:0] ACK_OK   = 8'h4B;
    localparam logic [7:0] ACK_ERR  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_MODE = 3'd1,
        ST_GET_FREQ = 3'd2,
        ST_CHECK    = 3'd3,
        ST_APPLY    = 3'd4
    } state_t;

    typedef enum logic {
        CMD_MODE = 1'b0,
        CMD_FREQ = 1'b1
    } cmd_t;

    state_t      state_r, state_nxt_s;
    cmd_t        cmd_r, cmd_nxt_s;
    logic [31:0] shadow_r, shadow_nxt_s;
    logic [7:0]  mode_byte_r, mode_byte_nxt_s;
    logic [1:0]  byte_cnt_r, byte_cnt_nxt_s;
    logic [31:0] tmo_cnt_r, tmo_cnt_nxt_s;
    logic [1:0]  mode_r, mode_nxt_s;
    logic [31:0] freq_r, freq_nxt_s;
    logic        update_r, update_nxt_s;
    logic        ack_s;
    logic [7:0]  ack_byte_s;
    logic        pend_r;
    logic [7:0]  pend_byte_r;
    logic        send_s;

    // Parser state, payload capture and inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_r       <= CMD_MODE;
            shadow_r    <= 32'd0;
            mode_byte_r <= 8'd0;
            byte_cnt_r  <= 2'd0;
            tmo_cnt_r   <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_r       <= cmd_nxt_s;
            shadow_r    <= shadow_nxt_s;
            mode_byte_r <= mode_byte_nxt_s;
            byte_cnt_r  <= byte_cnt_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
        end
    end

    // Generator control outputs, loaded only on the edge that enters APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r   <= DEFAULT_MODE;
            freq_r   <= DEF_FREQ_W;
            update_r <= 1'b0;
        end else begin
            mode_r   <= mode_nxt_s;
            freq_r   <= freq_nxt_s;
            update_r <= update_nxt_s;
        end
    end

    // Next-state decode, command validation and ack generation.
    always_comb begin
        state_nxt_s     = state_r;
        cmd_nxt_s       = cmd_r;
        shadow_nxt_s    = shadow_r;
        mode_byte_nxt_s = mode_byte_r;
        byte_cnt_nxt_s  = byte_cnt_r;
        tmo_cnt_nxt_s   = 32'd0;
        mode_nxt_s      = mode_r;
        freq_nxt_s      = freq_r;
        update_nxt_s    = 1'b0;
        ack_s           = 1'b0;
        ack_byte_s      = ACK_ERR;

        case (state_r)
            ST_IDLE: begin
                if (new_rx_data) begin
                    case (rx_data)
                        OP_MODE: begin
                            state_nxt_s = ST_GET_MODE;
                            cmd_nxt_s   = CMD_MODE;
                        end
                        OP_FREQ: begin
                            state_nxt_s    = ST_GET_FREQ;
                            cmd_nxt_s      = CMD_FREQ;
                            byte_cnt_nxt_s = 2'd0;
                            shadow_nxt_s   = 32'd0;
                        end
                        OP_RST: begin
                            // No payload: defaults are loaded on the way into APPLY.
                            state_nxt_s  = ST_APPLY;
                            mode_nxt_s   = DEFAULT_MODE;
                            freq_nxt_s   = DEF_FREQ_W;
                            update_nxt_s = 1'b1;
                        end
                        default: begin
                            ack_s      = 1'b1;
                            ack_byte_s = ACK_ERR;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GET_MODE: begin
                if (new_rx_data) begin
                    mode_byte_nxt_s = rx_data;
                    state_nxt_s     = ST_CHECK;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_IDLE;
                    ack_s       = 1'b1;
                    ack_byte_s  = ACK_ERR;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + 32'd1;
                end
            end
            ST_GET_FREQ: begin
                if (new_rx_data) begin
                    // Big-endian: the first payload byte ends up in bits [31:24].
                    shadow_nxt_s = {shadow_r[23:0], rx_data};
                    if (byte_cnt_r == 2'd3) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s  = ST_IDLE;
                    shadow_nxt_s = 32'd0;
                    ack_s        = 1'b1;
                    ack_byte_s   = ACK_ERR;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + 32'd1;
                end
            end
            ST_CHECK: begin
                if (cmd_r == CMD_MODE) begin
                    if (mode_byte_r[7:2] != 6'd0) begin
                        state_nxt_s = ST_IDLE;
                        ack_s       = 1'b1;
                        ack_byte_s  = ACK_ERR;
                    end else begin
                        state_nxt_s  = ST_APPLY;
                        mode_nxt_s   = mode_byte_r[1:0];
                        update_nxt_s = 1'b1;
                    end
                end else begin
                    if (shadow_r > MAX_FREQ_W) begin
                        state_nxt_s = ST_IDLE;
                        ack_s       = 1'b1;
                        ack_byte_s  = ACK_ERR;
                    end else begin
                        state_nxt_s  = ST_APPLY;
                        freq_nxt_s   = shadow_r;
                        update_nxt_s = 1'b1;
                    end
                end
            end
            ST_APPLY: begin
                state_nxt_s = ST_IDLE;
                ack_s       = 1'b1;
                ack_byte_s  = ACK_OK;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign send_s = pend_r & ~tx_busy;

    // Pending-ack holder: a newer ack overwrites an unsent one; sending clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= 1'b0;
            pend_byte_r <= 8'h00;
        end else if (ack_s) begin
            pend_r      <= 1'b1;
            pend_byte_r <= ack_byte_s;
        end else if (send_s) begin
            pend_r      <= 1'b0;
        end else begin
            pend_r      <= pend_r;
        end
    end

    assign new_tx_data = send_s;
    assign tx_data     = pend_byte_r;
    assign mode        = mode_r;
    assign freq        = freq_r;
    assign update      = update_r;

endmodule
